// File: rtl/alu_pkg.sv
// Shared constants for the multi-cycle datapath ALU: opcodes, FSM state
// encoding and the iteration count used by the Booth and divider loops.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 4;
    localparam int ITER_CNT  = ALU_WIDTH;

    // Operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_SHRA = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_NEG  = 4'd9;
    localparam logic [3:0] ALU_NOT  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;
    localparam logic [3:0] ALU_DIV  = 4'd12;

    // Control FSM state encoding
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SINGLE   = 3'd1;
    localparam logic [2:0] S_MUL_ITER = 3'd2;
    localparam logic [2:0] S_DIV_ITER = 3'd3;
    localparam logic [2:0] S_DIV_FIX  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    // First working state for an accepted opcode (undefined codes take the single-cycle path)
    function automatic logic [2:0] dispatch_state(input logic [3:0] opc);
        logic [2:0] st;
        case (opc)
            ALU_MUL: st = S_MUL_ITER;
            ALU_DIV: st = S_DIV_ITER;
            default: st = S_SINGLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/div_core.sv
// Signed non-restoring divider core. Works on operand magnitudes, one
// quotient bit per step; fix applies the final remainder correction and the
// sign fix-up (quotient truncated toward zero, remainder takes the dividend's
// sign) and registers the pair on the quotient/remainder outputs.
module div_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    // Partial remainder needs two guard bits: it spans [-2D, 2D) with D up to 2^(WIDTH-1)
    logic [WIDTH+1:0] part_r;
    logic [WIDTH-1:0] quo_work_r;
    logic [WIDTH-1:0] dvs_r;
    logic             neg_quo_r;
    logic             neg_rem_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] part_nxt_s;
    logic [WIDTH-1:0] rem_mag_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;

    // Magnitudes of the incoming operands (-2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned)
    always_comb begin
        dvd_mag_s = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
        dvs_mag_s = divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - divisor)  : divisor;
    end

    // One non-restoring step: subtract when the remainder is non-negative, add otherwise
    always_comb begin
        shifted_s = {part_r[WIDTH:0], quo_work_r[WIDTH-1]};
        if (part_r[WIDTH+1]) begin
            part_nxt_s = shifted_s + {2'b00, dvs_r};
        end else begin
            part_nxt_s = shifted_s - {2'b00, dvs_r};
        end
        // Final correction: a negative remainder gets one divisor added back; the
        // corrected value lies in [0, D) so modular low-half arithmetic is exact
        if (part_r[WIDTH+1]) begin
            rem_mag_s = part_r[WIDTH-1:0] + dvs_r;
        end else begin
            rem_mag_s = part_r[WIDTH-1:0];
        end
    end

    // Iteration registers and the sign-corrected output pair
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            part_r      <= '0;
            quo_work_r  <= '0;
            dvs_r       <= '0;
            neg_quo_r   <= 1'b0;
            neg_rem_r   <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else if (load) begin
            part_r      <= '0;
            quo_work_r  <= dvd_mag_s;
            dvs_r       <= dvs_mag_s;
            neg_quo_r   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_r   <= dividend[WIDTH-1];
        end else if (step) begin
            part_r      <= part_nxt_s;
            quo_work_r  <= {quo_work_r[WIDTH-2:0], ~part_nxt_s[WIDTH+1]};
        end else if (fix) begin
            quotient_r  <= neg_quo_r ? ({WIDTH{1'b0}} - quo_work_r) : quo_work_r;
            remainder_r <= neg_rem_r ? ({WIDTH{1'b0}} - rem_mag_s)  : rem_mag_s;
        end
    end

    assign quotient  = quotient_r;
    assign remainder = remainder_r;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle datapath ALU feeding the 64-bit Z register (HI = [63:32],
// LO = [31:0]). Logic/shift/add ops finish in one cycle, signed MUL uses an
// inline radix-2 Booth loop, signed DIV uses the div_core non-restoring unit.
// start/busy/done handshake; result is held until the next completed op.
// Optional macro ALU_DIVZERO_TRAP_EN: a DIV by zero finishes in one cycle and
// raises div_zero; without it div_zero is tied low and b==0 runs the full loop.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [OPW-1:0]     op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               div_zero
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam int              SH_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    logic [2:0]         state_r;
    logic [2:0]         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               accept_s;

    logic [OPW-1:0]     op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               divz_r;

    logic [WIDTH:0]     acc_r;
    logic [WIDTH-1:0]   mq_r;
    logic               qm1_r;
    logic [WIDTH:0]     mcand_s;
    logic [WIDTH:0]     booth_sum_s;

    logic               div_step_s;
    logic               div_fix_s;
    logic [WIDTH-1:0]   div_quo_s;
    logic [WIDTH-1:0]   div_rem_s;

    logic [2*WIDTH-1:0] result_r;
    logic [2*WIDTH-1:0] result_nxt_s;
    logic               busy_r;
    logic               done_r;

    // Single-cycle operations; shifts and rotates act on x by y[SH_W-1:0]
    function automatic logic [WIDTH-1:0] single_op(input logic [OPW-1:0]   opc,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        logic [SH_W-1:0]  shamt;
        logic [SH_W:0]    back;
        logic [WIDTH-1:0] f;
        shamt = y[SH_W-1:0];
        // Complementary shift for rotates; a zero amount yields a full-width shift, i.e. 0
        back  = (SH_W+1)'(WIDTH) - {1'b0, shamt};
        case (opc)
            ALU_ADD:  f = x + y;
            ALU_SUB:  f = x - y;
            ALU_AND:  f = x & y;
            ALU_OR:   f = x | y;
            ALU_SHR:  f = x >> shamt;
            ALU_SHRA: f = $unsigned($signed(x) >>> shamt);
            ALU_SHL:  f = x << shamt;
            ALU_ROR:  f = (x >> shamt) | (x << back);
            ALU_ROL:  f = (x << shamt) | (x >> back);
            ALU_NEG:  f = {WIDTH{1'b0}} - y;
            ALU_NOT:  f = ~y;
            default:  f = {WIDTH{1'b0}};
        endcase
        return f;
    endfunction

    assign accept_s = (state_r == S_IDLE) && start;

    // Next-state logic of the control FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
`ifdef ALU_DIVZERO_TRAP_EN
                    if ((op == ALU_DIV) && (b == {WIDTH{1'b0}})) begin
                        state_nxt_s = S_SINGLE;
                    end else begin
                        state_nxt_s = dispatch_state(op);
                    end
`else
                    state_nxt_s = dispatch_state(op);
`endif
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SINGLE:   state_nxt_s = S_DONE;
            // The cycle after the last Booth step registers the product with done
            S_MUL_ITER: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_MUL_ITER;
                end
            end
            // The cycle after the last divide step runs the core's fix-up
            S_DIV_ITER: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = S_DIV_FIX;
                end else begin
                    state_nxt_s = S_DIV_ITER;
                end
            end
            S_DIV_FIX:  state_nxt_s = S_DONE;
            S_DONE:     state_nxt_s = S_IDLE;
            default:    state_nxt_s = S_IDLE;
        endcase
    end

    // Iteration counter: cleared on accept, counts the shared MUL/DIV steps
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt_r <= '0;
        end else if (accept_s) begin
            cnt_r <= '0;
        end else if (((state_r == S_MUL_ITER) || (state_r == S_DIV_ITER)) && (cnt_r != LAST_CNT)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (state_r == S_DONE) begin
            cnt_r <= '0;
        end
    end

    // Operand latch so a and b may change once start has been accepted
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            divz_r <= 1'b0;
        end else if (accept_s) begin
            op_r   <= op;
            a_r    <= a;
            b_r    <= b;
            divz_r <= (b == {WIDTH{1'b0}});
        end
    end

    // Booth recoding of the multiplier's low bit pair
    always_comb begin
        mcand_s     = {a_r[WIDTH-1], a_r};
        booth_sum_s = acc_r;
        case ({mq_r[0], qm1_r})
            2'b01:   booth_sum_s = acc_r + mcand_s;
            2'b10:   booth_sum_s = acc_r - mcand_s;
            default: booth_sum_s = acc_r;
        endcase
    end

    // Booth accumulator and multiplier shift register, arithmetic shift right per step
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            acc_r <= '0;
            mq_r  <= '0;
            qm1_r <= 1'b0;
        end else if (accept_s) begin
            acc_r <= '0;
            mq_r  <= b;
            qm1_r <= 1'b0;
        end else if ((state_r == S_MUL_ITER) && (cnt_r != LAST_CNT)) begin
            acc_r <= {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
            mq_r  <= {booth_sum_s[0], mq_r[WIDTH-1:1]};
            qm1_r <= mq_r[0];
        end
    end

    assign div_step_s = (state_r == S_DIV_ITER) && (cnt_r != LAST_CNT);
    assign div_fix_s  = (state_r == S_DIV_ITER) && (cnt_r == LAST_CNT);

    div_core #(
        .WIDTH     (WIDTH)
    ) u_div_core (
        .clock     (clock),
        .clear     (clear),
        .load      (accept_s),
        .step      (div_step_s),
        .fix       (div_fix_s),
        .dividend  (a),
        .divisor   (b),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Value captured into result on the edge that enters DONE
    always_comb begin
        result_nxt_s = result_r;
        case (state_r)
            S_SINGLE: begin
                if (op_r == ALU_DIV) begin
                    result_nxt_s = {a_r, {WIDTH{1'b1}}};
                end else begin
                    result_nxt_s = {{WIDTH{1'b0}}, single_op(op_r, a_r, b_r)};
                end
            end
            S_MUL_ITER: result_nxt_s = {acc_r[WIDTH-1:0], mq_r};
            S_DIV_FIX: begin
                if (divz_r) begin
                    result_nxt_s = {a_r, {WIDTH{1'b1}}};
                end else begin
                    result_nxt_s = {div_rem_s, div_quo_s};
                end
            end
            default:    result_nxt_s = result_r;
        endcase
    end

    // FSM state and registered handshake/result outputs
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r  <= S_IDLE;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s == S_DONE);
            busy_r  <= !accept_s && ((state_nxt_s == S_SINGLE) || (state_nxt_s == S_MUL_ITER) ||
                                     (state_nxt_s == S_DIV_ITER) || (state_nxt_s == S_DIV_FIX));
            if (state_nxt_s == S_DONE) begin
                result_r <= result_nxt_s;
            end
        end
    end

`ifdef ALU_DIVZERO_TRAP_EN
    logic div_zero_r;

    // Trapped divide-by-zero is the only DIV that takes the single-cycle path
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            div_zero_r <= 1'b0;
        end else begin
            div_zero_r <= (state_r == S_SINGLE) && (op_r == ALU_DIV);
        end
    end

    assign div_zero = div_zero_r;
`else
    assign div_zero = 1'b0;
`endif

    assign result = result_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases plus randomized ops
// against a behavioural reference model. Honours ALU_DIVZERO_TRAP_EN.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] result;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_cmp = 0;
    int n_err = 0;

`ifdef ALU_DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always #5 clock = ~clock;

    alu_multicycle dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic from the operation definitions
    function automatic logic [63:0] ref_result(input logic [3:0] opc, input logic [31:0] x,
                                               input logic [31:0] y);
        logic [31:0] f;
        int          s;
        longint      px, py, q, r, w;
        logic [63:0] qv, rv, wv;
        s  = int'(y[4:0]);
        px = longint'($signed(x));
        py = longint'($signed(y));
        f  = 32'd0;
        case (opc)
            ALU_ADD:  f = x + y;
            ALU_SUB:  f = x - y;
            ALU_AND:  f = x & y;
            ALU_OR:   f = x | y;
            ALU_SHR:  f = x >> s;
            ALU_SHRA: begin w = px >>> s; wv = w; f = wv[31:0]; end
            ALU_SHL:  f = x << s;
            ALU_ROR:  begin f = x; repeat (s) f = {f[0], f[31:1]}; end
            ALU_ROL:  begin f = x; repeat (s) f = {f[30:0], f[31]}; end
            ALU_NEG:  f = 32'd0 - y;
            ALU_NOT:  f = ~y;
            ALU_MUL:  begin w = px * py; wv = w; return wv; end
            ALU_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = px / py;
                r = px % py;
                qv = q;
                rv = r;
                return {rv[31:0], qv[31:0]};
            end
            default:  f = 32'd0;
        endcase
        return {32'd0, f};
    endfunction

    function automatic int ref_latency(input logic [3:0] opc, input logic [31:0] y);
        if (opc == ALU_MUL) return 33;
        if (opc == ALU_DIV) return (TRAP && (y == 32'd0)) ? 1 : 34;
        return 1;
    endfunction

    // Issue one op; optionally pulse a stray start during the run or in the done cycle
    task automatic run_op(input logic [3:0] opc, input logic [31:0] x, input logic [31:0] y,
                          input int inject_at, input bit poke_done, input string tag);
        logic [63:0] exp_res;
        int          exp_lat, lat, busy_cnt, n_done;
        logic        exp_dz, seen_dz;
        exp_res = ref_result(opc, x, y);
        exp_lat = ref_latency(opc, y);
        exp_dz  = TRAP && (opc == ALU_DIV) && (y == 32'd0);
        @(negedge clock);
        op = opc; a = x; b = y; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
        lat = 0; seen_dz = 1'b0;
        busy_cnt = busy ? 1 : 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc == inject_at) begin
                op = ALU_ADD; start = 1'b1;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = cyc;
                seen_dz = div_zero;
                break;
            end
        end
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "/result"}, result, exp_res);
        check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        check({tag, "/div_zero"}, 64'(seen_dz), 64'(exp_dz));
        if (poke_done) begin
            op = ALU_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        check({tag, "/done_pulse"}, 64'(done), 64'd0);
        if (poke_done) begin
            n_done = 0;
            repeat (4) begin
                @(posedge clock);
                #1;
                if (done) n_done++;
            end
            check({tag, "/ignored_start"}, 64'(n_done), 64'd0);
            check({tag, "/result_held"}, result, exp_res);
        end
    endtask

    initial begin
        int n_done;
        logic [3:0]  ropc;
        logic [31:0] ra, rb;
        logic [31:0] specials [4];
        specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000; specials[3] = 32'h0000_0001;

        clear = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset/result", result, 64'd0);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/div_zero", 64'(div_zero), 64'd0);
        @(negedge clock);
        clear = 1'b0;

        // Directed cases
        run_op(ALU_ADD, 32'd5, 32'd7, -1, 1'b0, "add_5_7");
        check("add_5_7/value", result, 64'h0000_0000_0000_000C);
        run_op(ALU_MUL, 32'hFFFF_FFFD, 32'd7, -1, 1'b0, "mul_m3_7");
        check("mul_m3_7/value", result, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(ALU_DIV, 32'hFFFF_FFEF, 32'd5, -1, 1'b0, "div_m17_5");
        check("div_m17_5/value", result, 64'hFFFF_FFFE_FFFF_FFFD);
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, "div_min_m1");
        check("div_min_m1/value", result, 64'h0000_0000_8000_0000);
        run_op(ALU_ROR, 32'd1, 32'd1, -1, 1'b0, "ror_1_1");
        check("ror_1_1/value", result, 64'h0000_0000_8000_0000);
        run_op(ALU_SHRA, 32'h8000_0000, 32'd4, -1, 1'b0, "shra_min_4");
        check("shra_min_4/value", result, 64'h0000_0000_F800_0000);
        run_op(ALU_ROL, 32'h1234_5678, 32'd0, -1, 1'b0, "rol_by_0");
        run_op(ALU_SHL, 32'h1234_5678, 32'd32, -1, 1'b0, "shl_by_32");
        run_op(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, -1, 1'b0, "undef_op");
        run_op(ALU_DIV, 32'd9, 32'd0, -1, 1'b0, "div_9_0");
        check("div_9_0/value", result, 64'h0000_0009_FFFF_FFFF);
        run_op(ALU_MUL, 32'h8000_0000, 32'h8000_0000, -1, 1'b0, "mul_min_min");

        // Stray start while busy and while done must be ignored
        run_op(ALU_MUL, 32'd123_456, 32'hFFFF_0001, 5, 1'b1, "mul_restart");
        run_op(ALU_DIV, 32'd1000, 32'hFFFF_FFF9, 20, 1'b1, "div_restart");

        // Abort a MUL with clear in cycle 10
        run_op(ALU_ADD, 32'd5, 32'd7, -1, 1'b0, "pre_abort");
        @(negedge clock);
        op = ALU_MUL; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("abort/busy_before", 64'(busy), 64'd1);
        clear = 1'b1;
        #1;
        check("abort/busy", 64'(busy), 64'd0);
        check("abort/result", result, 64'd0);
        check("abort/done", 64'(done), 64'd0);
        @(negedge clock);
        clear = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) n_done++;
        end
        check("abort/no_done", 64'(n_done), 64'd0);
        run_op(ALU_ADD, 32'd100, 32'd23, -1, 1'b0, "post_abort_add");

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ropc = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 35));
                1:       rb = specials[$urandom_range(0, 3)];
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            run_op(ropc, ra, rb, -1, 1'b0, $sformatf("rand%0d_op%0d", i, ropc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
